pet_keymatrix: RTL and testbench

PS/2-keyboard-to-PET keyboard matrix responder. It sits on the other end of the PET hardware's keyboard scan interface. It receives serial PS/2 frames and decodes make/break/extended prefixes. Each scancode is mapped to a matrix position through an external combinational keymap lookup, and the block keeps a 10×8 key-state matrix. It answers the hardware's 4-bit row select with the 8-bit active-low column byte.

---
 rtl/pet_keymatrix.sv | 252 +++++++++++++++++++++++++
 tb/tb_pet_keymatrix.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pet_keymatrix.sv
// PS/2 keyboard to PET 10x8 key matrix responder.
// Decodes make/break/E0 scancodes and answers the row scan with active-low columns.
module pet_keymatrix #(
  parameter int FILT    = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] keyrow,
  output logic [7:0] keyin,
  output logic [7:0] map_code,
  output logic       map_ext,
  input  logic       map_hit,
  input  logic [3:0] map_row,
  input  logic [2:0] map_col,
  output logic       key_event,
  output logic       frame_err
);

  localparam int FW = $clog2(FILT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FLAST = FW'(FILT - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXTBRK,
    S_APPLY
  } state_t;

  logic          r_clk_s1, r_clk_s2;
  logic          r_dat_s1, r_dat_s2;
  logic          r_clk_f;
  logic [FW-1:0] r_fcnt;
  logic [10:0]   r_shift;
  logic [3:0]    r_bitcnt;
  logic [TW-1:0] r_tocnt;
  logic          r_done;
  logic          r_byte_vld;
  logic [7:0]    r_byte;
  logic          r_ferr;
  logic          r_hold_vld;
  logic [7:0]    r_hold;
  state_t        r_state, w_next;
  logic [7:0]    r_code;
  logic          r_ext;
  logic          r_brk;
  logic          r_kev;
  logic [7:0]    r_keyin;
  logic [7:0]    r_mat [0:9];

  logic          w_strobe;
  logic          w_frame_ok;
  logic          w_in_vld;
  logic [7:0]    w_in;
  logic          w_ld;
  logic          w_ld_ext;
  logic          w_ld_brk;
  logic          w_clr;
  logic          w_write;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Filtered clock only moves after FILT consecutive cycles at the new level
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clk_f <= 1'b1;
      r_fcnt  <= '0;
    end else if (r_clk_s2 == r_clk_f) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FLAST) begin
      r_clk_f <= r_clk_s2;
      r_fcnt  <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end

  assign w_strobe   = r_clk_f & ~r_clk_s2 & (r_fcnt == FLAST);
  assign w_frame_ok = ~r_shift[0] & r_shift[10] & (^r_shift[9:1]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_tocnt    <= '0;
      r_done     <= 1'b0;
      r_byte_vld <= 1'b0;
      r_byte     <= '0;
      r_ferr     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_byte_vld <= 1'b0;
      r_ferr     <= 1'b0;
      if (w_strobe) begin
        r_shift <= {r_dat_s2, r_shift[10:1]};
        r_tocnt <= '0;
        if (r_bitcnt == 4'd10) begin
          r_bitcnt <= '0;
          r_done   <= 1'b1;
        end else begin
          r_bitcnt <= r_bitcnt + 1'b1;
        end
      end else if (r_bitcnt != 4'd0) begin
        if (r_tocnt == TLAST) begin
          r_bitcnt <= '0;
          r_tocnt  <= '0;
        end else begin
          r_tocnt <= r_tocnt + 1'b1;
        end
      end
      if (r_done) begin
        if (w_frame_ok) begin
          r_byte     <= r_shift[8:1];
          r_byte_vld <= 1'b1;
        end else begin
          r_ferr <= 1'b1;
        end
      end
    end
  end

  // A byte landing during APPLY waits one cycle in the holding register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hold_vld <= 1'b0;
      r_hold     <= '0;
    end else if (r_state == S_APPLY && r_byte_vld) begin
      r_hold_vld <= 1'b1;
      r_hold     <= r_byte;
    end else if (r_state != S_APPLY) begin
      r_hold_vld <= 1'b0;
    end
  end

  assign w_in_vld = (r_byte_vld | r_hold_vld) & (r_state != S_APPLY);
  assign w_in     = r_hold_vld ? r_hold : r_byte;

  always_comb begin
    w_next   = r_state;
    w_ld     = 1'b0;
    w_ld_ext = 1'b0;
    w_ld_brk = 1'b0;
    w_clr    = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        if (w_in_vld) begin
          if (w_in == 8'hE0) begin
            w_next = S_EXT;
          end else if (w_in == 8'hF0) begin
            w_next = S_BRK;
          end else if (w_in == 8'hE1) begin
            w_next = S_IDLE;
          end else if (w_in == 8'h00 || w_in == 8'hFF) begin
            w_clr = 1'b1;
          end else begin
            w_next = S_APPLY;
            w_ld   = 1'b1;
          end
        end
      end
      (r_state == S_EXT): begin
        if (w_in_vld) begin
          if (w_in == 8'hF0) begin
            w_next = S_EXTBRK;
          end else if (w_in != 8'hE0 && w_in != 8'hE1) begin
            w_next   = S_APPLY;
            w_ld     = 1'b1;
            w_ld_ext = 1'b1;
          end
        end
      end
      (r_state == S_BRK): begin
        if (w_in_vld) begin
          w_next   = S_APPLY;
          w_ld     = 1'b1;
          w_ld_brk = 1'b1;
        end
      end
      (r_state == S_EXTBRK): begin
        if (w_in_vld) begin
          w_next   = S_APPLY;
          w_ld     = 1'b1;
          w_ld_ext = 1'b1;
          w_ld_brk = 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ld) begin
        r_code <= w_in;
        r_ext  <= w_ld_ext;
        r_brk  <= w_ld_brk;
      end
    end
  end

  assign w_write = (r_state == S_APPLY) & map_hit & (map_row <= 4'd9);

  always_ff @(posedge clk) begin
    if (!reset || w_clr) begin
      for (int i = 0; i < 10; i++) r_mat[i] <= '0;
    end else if (w_write) begin
      r_mat[map_row][map_col] <= ~r_brk;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_kev   <= 1'b0;
      r_keyin <= 8'hFF;
    end else begin
      r_kev   <= w_write;
      r_keyin <= (keyrow <= 4'd9) ? ~r_mat[keyrow] : 8'hFF;
    end
  end

  assign keyin     = r_keyin;
  assign map_code  = r_code;
  assign map_ext   = r_ext;
  assign key_event = r_kev;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_pet_keymatrix.sv
// Scoreboard bench for pet_keymatrix: PS/2 frames in, key events
// and column bytes checked against a bench-side keymap and matrix model.
module tb_pet_keymatrix;

  localparam int FILT = 4;
  localparam int TOUT = 2000;

  typedef struct {
    logic [7:0] code;
    logic       ext;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] keyrow = 4'd0;
  logic [7:0] keyin;
  logic [7:0] map_code;
  logic       map_ext;
  logic       map_hit;
  logic [3:0] map_row;
  logic [2:0] map_col;
  logic       key_event;
  logic       frame_err;

  int   n_cmp = 0;
  int   n_err = 0;
  ev_t  exp_q[$];
  int   exp_ferr = 0;
  bit   mon_en = 1'b0;
  logic [7:0] mdl [0:9];

  pet_keymatrix #(.FILT(FILT), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyrow(keyrow), .keyin(keyin),
    .map_code(map_code), .map_ext(map_ext),
    .map_hit(map_hit), .map_row(map_row), .map_col(map_col),
    .key_event(key_event), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // {hit, row[3:0], col[2:0]}
  function automatic logic [7:0] kmap(input logic e, input logic [7:0] c);
    case ({e, c})
      9'h01C:  return {1'b1, 4'd4, 3'd0};
      9'h175:  return {1'b1, 4'd2, 3'd7};
      9'h016:  return {1'b1, 4'd0, 3'd3};
      9'h01A:  return {1'b1, 4'd9, 3'd5};
      9'h021:  return {1'b1, 4'd11, 3'd1};
      default: return 8'h00;
    endcase
  endfunction

  always_comb {map_hit, map_row, map_col} = kmap(map_ext, map_code);

  always @(negedge clk) begin
    if (mon_en) begin
      if (key_event) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL key_event: unexpected code=%h ext=%b", map_code, map_ext);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (map_code !== e.code || map_ext !== e.ext) begin
            n_err++;
            $display("FAIL key_event_map: got code=%h ext=%b want code=%h ext=%b",
                     map_code, map_ext, e.code, e.ext);
          end
        end
      end
      if (frame_err) begin
        n_cmp++;
        if (exp_ferr == 0) begin
          n_err++;
          $display("FAIL frame_err: unexpected pulse");
        end else begin
          exp_ferr--;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    tick(20);
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out((~^b) ^ bad_par);
    bit_out(~bad_stop);
    ps2_data = 1'b1;
    tick(40);
  endtask

  task automatic press(input logic ext, input logic brk, input logic [7:0] code);
    logic [7:0] m;
    ev_t e;
    m = kmap(ext, code);
    if (ext) send_frame(8'hE0, 0, 0);
    if (brk) send_frame(8'hF0, 0, 0);
    if (m[7] && m[6:3] <= 4'd9) begin
      e.code = code;
      e.ext  = ext;
      exp_q.push_back(e);
      mdl[m[6:3]][m[2:0]] = ~brk;
    end
    send_frame(code, 0, 0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(3);
    n_cmp++;
    if (keyin !== 8'hFF || key_event !== 1'b0 || frame_err !== 1'b0 ||
        map_code !== 8'h00 || map_ext !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: keyin=%h kev=%b ferr=%b code=%h ext=%b want FF/0/0/00/0",
               keyin, key_event, frame_err, map_code, map_ext);
    end
    reset = 1'b1;
    mon_en = 1'b1;
    tick(5);
  endtask

  task automatic test_make;
    keyrow = 4'd4;
    press(0, 0, 8'h1C);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL make_event: %0d events outstanding, want 0", exp_q.size());
    end
    n_cmp++;
    if (keyin !== 8'hFE) begin
      n_err++;
      $display("FAIL make_keyin: got %h want FE", keyin);
    end
    press(0, 1, 8'h1C);
    n_cmp++;
    if (keyin !== 8'hFF || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL break_keyin: got %h want FF (pending %0d)", keyin, exp_q.size());
    end
  endtask

  task automatic test_ext;
    keyrow = 4'd2;
    press(1, 0, 8'h75);
    n_cmp++;
    if (keyin !== 8'h7F || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL ext_make: got %h want 7F (pending %0d)", keyin, exp_q.size());
    end
    press(1, 1, 8'h75);
    n_cmp++;
    if (keyin !== 8'hFF || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL ext_break: got %h want FF (pending %0d)", keyin, exp_q.size());
    end
  endtask

  task automatic test_frame_err;
    keyrow = 4'd4;
    exp_ferr++;
    send_frame(8'h1C, 1, 0);
    n_cmp++;
    if (keyin !== 8'hFF || exp_ferr != 0) begin
      n_err++;
      $display("FAIL bad_parity: keyin=%h want FF, ferr pending %0d want 0", keyin, exp_ferr);
    end
    exp_ferr++;
    send_frame(8'h1C, 0, 1);
    n_cmp++;
    if (keyin !== 8'hFF || exp_ferr != 0) begin
      n_err++;
      $display("FAIL bad_stop: keyin=%h want FF, ferr pending %0d want 0", keyin, exp_ferr);
    end
  endtask

  task automatic test_timeout;
    keyrow = 4'd4;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    ps2_data = 1'b1;
    tick(TOUT + 10);
    press(0, 0, 8'h1C);
    n_cmp++;
    if (keyin !== 8'hFE || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL timeout_decode: got %h want FE (pending %0d)", keyin, exp_q.size());
    end
    press(0, 1, 8'h1C);
    n_cmp++;
    if (keyin !== 8'hFF) begin
      n_err++;
      $display("FAIL timeout_break: got %h want FF", keyin);
    end
  endtask

  task automatic test_rows;
    logic [7:0] want;
    press(0, 0, 8'h16);
    press(0, 0, 8'h1A);
    press(0, 0, 8'h1C);
    press(0, 0, 8'h21);
    for (int r = 0; r < 16; r++) begin
      keyrow = 4'(r);
      tick(1);
      want = (r <= 9) ? ~mdl[r] : 8'hFF;
      n_cmp++;
      if (keyin !== want) begin
        n_err++;
        $display("FAIL row_sweep: row %0d got %h want %h", r, keyin, want);
      end
    end
    send_frame(8'hFF, 0, 0);
    for (int r = 0; r < 10; r++) mdl[r] = 8'h00;
    for (int r = 0; r < 16; r++) begin
      keyrow = 4'(r);
      tick(1);
      n_cmp++;
      if (keyin !== 8'hFF) begin
        n_err++;
        $display("FAIL clear_all: row %0d got %h want FF", r, keyin);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rows_events: %0d outstanding want 0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset;
    keyrow = 4'd4;
    press(0, 0, 8'h1C);
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b0);
    reset = 1'b0;
    tick(2);
    n_cmp++;
    if (keyin !== 8'hFF || map_code !== 8'h00 || map_ext !== 1'b0 ||
        key_event !== 1'b0 || frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: keyin=%h code=%h ext=%b kev=%b ferr=%b",
               keyin, map_code, map_ext, key_event, frame_err);
    end
    ps2_data = 1'b1;
    reset = 1'b1;
    for (int r = 0; r < 10; r++) mdl[r] = 8'h00;
    tick(5);
    n_cmp++;
    if (keyin !== 8'hFF) begin
      n_err++;
      $display("FAIL midreset_matrix: got %h want FF", keyin);
    end
    keyrow = 4'd0;
    press(0, 0, 8'h16);
    n_cmp++;
    if (keyin !== 8'hF7 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL after_reset: got %h want F7 (pending %0d)", keyin, exp_q.size());
    end
  endtask

  initial begin
    for (int r = 0; r < 10; r++) mdl[r] = 8'h00;
    test_reset();
    test_make();
    test_ext();
    test_frame_err();
    test_timeout();
    test_rows();
    test_mid_reset();
    tick(20);
    n_cmp++;
    if (exp_q.size() != 0 || exp_ferr != 0) begin
      n_err++;
      $display("FAIL drain: events %0d ferr %0d outstanding want 0", exp_q.size(), exp_ferr);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
